// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: filtered kclk/kdata sampling, frame checking,
// E0/F0 prefix folding and a show-ahead event FIFO, all in the clk domain.
module ps2_key_event_rx #(
    parameter int FILTER_LEN   = 4,
    parameter int TIMEOUT_CYC  = 100000,
    parameter int FIFO_DEPTH   = 8,
    parameter int CHECK_PARITY = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               kclk,
    input  logic                               kdata,
    input  logic                               rd_en,
    output logic                               ev_valid,
    output logic [7:0]                         ev_code,
    output logic                               ev_ext,
    output logic                               ev_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    ev_count,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic                               overflow,
    input  logic                               clr_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    logic                  kclk_s1_q, kclk_s2_q, kdata_s1_q, kdata_s2_q;
    logic [FILTER_LEN-1:0] kclk_sh_q, kclk_sh_d, kdata_sh_q, kdata_sh_d;
    logic                  kclk_f_q, kclk_f_d, kdata_f_q, kdata_f_d;
    logic                  fall_q, fall_d;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            data_q, data_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic                  frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                  byte_ok;

    logic                  push, pop, push_ok;
    logic [9:0]            push_data, head;
    logic [9:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ev_count_q, ev_count_d;
    logic                  overflow_q, overflow_d;

    function automatic logic odd_parity_bad(input logic [7:0] d, input logic p);
        return ((^d) ^ p) == 1'b0;
    endfunction

    // ---- input conditioning: synchroniser, agreement filter, fall detect ----
    always_comb begin
        kclk_sh_d  = {kclk_sh_q[FILTER_LEN-2:0], kclk_s2_q};
        kdata_sh_d = {kdata_sh_q[FILTER_LEN-2:0], kdata_s2_q};
        kclk_f_d   = kclk_f_q;
        kdata_f_d  = kdata_f_q;
        if (&kclk_sh_q)        kclk_f_d = 1'b1;
        else if (~|kclk_sh_q)  kclk_f_d = 1'b0;
        if (&kdata_sh_q)       kdata_f_d = 1'b1;
        else if (~|kdata_sh_q) kdata_f_d = 1'b0;
        fall_d = kclk_f_q & ~kclk_f_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kclk_s1_q  <= 1'b1;
            kclk_s2_q  <= 1'b1;
            kdata_s1_q <= 1'b1;
            kdata_s2_q <= 1'b1;
            kclk_sh_q  <= '1;
            kdata_sh_q <= '1;
            kclk_f_q   <= 1'b1;
            kdata_f_q  <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            kclk_s1_q  <= kclk;
            kclk_s2_q  <= kclk_s1_q;
            kdata_s1_q <= kdata;
            kdata_s2_q <= kdata_s1_q;
            kclk_sh_q  <= kclk_sh_d;
            kdata_sh_q <= kdata_sh_d;
            kclk_f_q   <= kclk_f_d;
            kdata_f_q  <= kdata_f_d;
            fall_q     <= fall_d;
        end
    end

    // ---- frame FSM, timeout and prefix folding ----
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        byte_ok      = 1'b0;
        push         = 1'b0;
        push_data    = {ext_pend_q, brk_pend_q, data_q};

        if (fall_q) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!kdata_f_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    data_d    = {kdata_f_q, data_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PAR;
                end
                PAR: begin
                    par_d   = kdata_f_q;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!kdata_f_q)
                        frame_err_d = 1'b1;
                    else if ((CHECK_PARITY != 0) && odd_parity_bad(data_q, par_q))
                        parity_err_d = 1'b1;
                    else
                        byte_ok = 1'b1;
                end
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (frame_err_d || parity_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_ok) begin
            if (data_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (data_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // ---- show-ahead event FIFO; a full FIFO still accepts when popped together ----
    always_comb begin
        pop        = rd_en && (ev_count_q != '0);
        push_ok    = push && ((ev_count_q < CW'(FIFO_DEPTH)) || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ev_count_d = ev_count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (push & ~push_ok);
        if (clr_err) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ev_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ev_count_q <= ev_count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (ev_count_q != '0);
    assign ev_code    = ev_valid ? head[7:0] : 8'h00;
    assign ev_break   = ev_valid & head[8];
    assign ev_ext     = ev_valid & head[9];
    assign ev_count   = ev_count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Randomised scoreboard bench for ps2_key_event_rx: a byte-level keyboard
// model predicts events and error pulses; a monitor pops and compares events.
module tb_ps2_key_event_rx;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam int FIFO_DEPTH  = 8;
    localparam int CW          = $clog2(FIFO_DEPTH + 1);
    localparam int KGOOD = 0, KPAR = 1, KSTOP = 2;

    logic          clk = 1'b0;
    logic          rstn, kclk, kdata, rd_en, clr_err;
    logic          ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow;
    logic [7:0]    ev_code;
    logic [CW-1:0] ev_count;

    ps2_key_event_rx #(
        .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH(FIFO_DEPTH), .CHECK_PARITY(1)
    ) dut (
        .clk(clk), .rstn(rstn), .kclk(kclk), .kdata(kdata), .rd_en(rd_en),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_count(ev_count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    logic [9:0] exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0, exp_ovf = 1'b0;
    int exp_fe = 0, exp_pe = 0, fe_seen = 0, pe_seen = 0;
    bit pop_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Byte-level keyboard model: prefixes accumulate, any bad frame forgets them.
    task automatic model_byte(input logic [7:0] code, input int kind);
        if (kind == KPAR || kind == KSTOP) begin
            if (kind == KPAR) exp_pe++; else exp_fe++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() == FIFO_DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, code});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input int kind, input int nbits,
                              input int glitch_at);
        logic [10:0] f;
        int half;
        half = 16 + $urandom_range(0, 8);
        f = {(kind == KSTOP) ? 1'b0 : 1'b1, (~^code) ^ (kind == KPAR), code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdata = f[i];
            if (i == glitch_at) begin
                cyc(half / 2); kclk = 1'b0; cyc(2); kclk = 1'b1; cyc(half - half / 2 - 2);
            end else begin
                cyc(half);
            end
            kclk = 1'b0;
            cyc(half);
            kclk = 1'b1;
        end
        kdata = 1'b1;
        cyc(30);
    endtask

    task automatic send_byte(input logic [7:0] code, input int kind, input int glitch_at);
        model_byte(code, kind);
        send_frame(code, kind, 11, glitch_at);
        cyc($urandom_range(0, 20));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && (exp_q.size() != 0 || ev_valid); i++) cyc(1);
        check(name, exp_q.size(), 0);
        check({name, "_valid"}, int'(ev_valid), 0);
    endtask

    // Monitor: count error pulses, pop and score events whenever popping is enabled.
    initial begin
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (frame_err)  fe_seen++;
            if (parity_err) pe_seen++;
            if (rd_en) begin
                rd_en = 1'b0;
            end else if (ev_valid && pop_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_event: got 0x%0h expected none",
                             {ev_ext, ev_break, ev_code});
                end else begin
                    exp = exp_q.pop_front();
                    check("event", int'({ev_ext, ev_break, ev_code}), int'(exp));
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        rstn = 1'b0; kclk = 1'b1; kdata = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        cyc(5);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_count", int'(ev_count), 0);
        check("rst_errs", int'({frame_err, parity_err, overflow}), 0);
        rstn = 1'b1;
        cyc(20);

        // single make code, then one pop
        send_byte(8'h1C, KGOOD, -1);
        check("t1_valid", int'(ev_valid), 1);
        check("t1_count", int'(ev_count), 1);
        check("t1_head", int'({ev_ext, ev_break, ev_code}), 10'h01C);
        pop_en = 1'b1;
        drain("t1_drain");
        check("t1_count0", int'(ev_count), 0);

        // prefix folding
        send_byte(8'hF0, KGOOD, -1);
        send_byte(8'h1C, KGOOD, -1);
        send_byte(8'hE0, KGOOD, -1);
        send_byte(8'hF0, KGOOD, -1);
        send_byte(8'h75, KGOOD, -1);
        send_byte(8'hE0, KGOOD, -1);
        send_byte(8'hE0, KGOOD, -1);
        send_byte(8'h1C, KGOOD, -1);
        drain("t2_drain");
        check("t2_fe", fe_seen, exp_fe);
        check("t2_pe", pe_seen, exp_pe);

        // parity error drops byte and prefixes
        send_byte(8'h1C, KPAR, -1);
        check("t3_pe", pe_seen, exp_pe);
        check("t3_count", int'(ev_count), 0);
        send_byte(8'hF0, KPAR, -1);
        send_byte(8'h1C, KGOOD, -1);
        drain("t3_drain");

        // timeout mid-frame after a pending E0
        send_byte(8'hE0, KGOOD, -1);
        exp_fe++; m_ext = 1'b0; m_brk = 1'b0;
        send_frame(8'h55, KGOOD, 4, -1);
        cyc(TIMEOUT_CYC + 20);
        check("t4_fe", fe_seen, exp_fe);
        send_byte(8'h29, KGOOD, -1);
        drain("t4_drain");
        send_byte(8'h33, KSTOP, -1);
        check("t4_stop_fe", fe_seen, exp_fe);

        // overflow
        pop_en = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i), KGOOD, -1);
        check("t5_count", int'(ev_count), FIFO_DEPTH);
        check("t5_ovf", int'(overflow), int'(exp_ovf));
        check("t5_head", int'(ev_code), 8'h15);
        pop_en = 1'b1;
        drain("t5_drain");
        check("t5_ovf_sticky", int'(overflow), 1);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(1);
        check("t5_clr", int'(overflow), 0);

        // reset mid-frame wipes queued events and the partial byte
        pop_en = 1'b0;
        send_byte(8'h44, KGOOD, -1);
        send_byte(8'hF0, KGOOD, -1);
        send_frame(8'h5A, KGOOD, 6, -1);
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", int'(ev_valid), 0);
        check("t6_rst_count", int'(ev_count), 0);
        exp_q.delete(); m_ext = 1'b0; m_brk = 1'b0;
        cyc(4);
        rstn = 1'b1;
        pop_en = 1'b1;
        cyc(10);
        kclk = 1'b0; cyc(2); kclk = 1'b1; cyc(20);
        check("t6_glitch_fe", fe_seen, exp_fe);
        send_byte(8'h5A, KGOOD, 3);
        drain("t6_drain");

        // random traffic
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 9);
            c = 8'($urandom_range(0, 255));
            if (c == 8'hE0 || c == 8'hF0) c = 8'h1C;
            case (r)
                0:       send_byte(8'hE0, KGOOD, -1);
                1:       send_byte(8'hF0, KGOOD, -1);
                2:       send_byte(c, KPAR, -1);
                3:       send_byte(c, KSTOP, -1);
                default: send_byte(c, KGOOD, -1);
            endcase
        end
        drain("rand_drain");
        check("rand_fe", fe_seen, exp_fe);
        check("rand_pe", pe_seen, exp_pe);
        check("final_ovf", int'(overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
